// File: rtl/sync_updown_counter_pkg.sv
// Shared counter definitions: mode constants and load clamping used by
// the up/down counter and future prescaler/timer blocks.
package counter_pkg;

    localparam int unsigned CNT_WRAP = 0;
    localparam int unsigned CNT_SAT  = 1;

    function automatic longint unsigned clamp_to_mod(longint unsigned value,
                                                     longint unsigned mod_n);
        return (value >= mod_n) ? mod_n - 64'd1 : value;
    endfunction

endpackage

// File: rtl/sync_updown_counter_count_step.sv
// Combinational next-count and event computation for sync_updown_counter.
module count_step
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MOD_N    = 256,
    parameter int unsigned SATURATE = 0
) (
    input  logic [WIDTH-1:0] q,
    input  logic             up,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             at_bound,
    output logic [WIDTH-1:0] q_next,
    output logic             wrap_next,
    output logic             sat_next
);

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MOD_N - 1);
    localparam bit               SAT   = (SATURATE == CNT_SAT);

    logic             at_top;
    logic             at_bot;
    logic [WIDTH-1:0] ld_clamped;

    assign at_top     = (q == MAX_Q);
    assign at_bot     = (q == '0);
    assign ld_clamped = WIDTH'(clamp_to_mod(64'(load_val), 64'(MOD_N)));

    always_comb begin
        q_next    = q;
        wrap_next = 1'b0;
        sat_next  = 1'b0;
        if (load) begin
            q_next   = ld_clamped;
            sat_next = SAT && (up ? (ld_clamped == MAX_Q) : (ld_clamped == '0));
        end else if (en) begin
            if (up) begin
                if (!at_top)
                    q_next = q + 1'b1;
                else if (SAT)
                    sat_next = 1'b1;
                else begin
                    q_next    = '0;
                    wrap_next = 1'b1;
                end
            end else begin
                if (!at_bot)
                    q_next = q - 1'b1;
                else if (SAT)
                    sat_next = 1'b1;
                else begin
                    q_next    = MAX_Q;
                    wrap_next = 1'b1;
                end
            end
        end else begin
            // Idle: the flag survives only while q still sits on the bound for this direction
            sat_next = SAT && at_bound && (up ? at_top : at_bot);
        end
    end

endmodule

// File: rtl/sync_updown_counter.sv
// Synchronous modulo-N up/down counter with load, enable, wrap/saturate
// modes and a cascadable terminal-count output.
module sync_updown_counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MOD_N    = 256,
    parameter int unsigned SATURATE = CNT_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             at_bound
);

    localparam logic [WIDTH-1:0] MAX_Q  = WIDTH'(MOD_N - 1);
    localparam bit               MOD_OK = (WIDTH >= 1) && (WIDTH <= 64) && (MOD_N >= 2) &&
                                          ((WIDTH >= 32) || (64'(MOD_N) <= (64'd1 << WIDTH)));

    if (!MOD_OK) begin : g_bad_params
        $error("sync_updown_counter: MOD_N must satisfy 2 <= MOD_N <= 2**WIDTH");
    end

    logic [WIDTH-1:0] q_next;
    logic             wrap_next;
    logic             sat_next;

    count_step #(
        .WIDTH   (WIDTH),
        .MOD_N   (MOD_N),
        .SATURATE(SATURATE)
    ) u_step (
        .q        (q),
        .up       (up),
        .en       (en),
        .load     (load),
        .load_val (load_val),
        .at_bound (at_bound),
        .q_next   (q_next),
        .wrap_next(wrap_next),
        .sat_next (sat_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q        <= '0;
            wrap     <= 1'b0;
            at_bound <= 1'b0;
        end else begin
            q        <= q_next;
            wrap     <= wrap_next;
            at_bound <= sat_next;
        end
    end

    assign tc = en & ((up & (q == MAX_Q)) | (~up & (q == '0)));

endmodule

// File: tb/tb_sync_updown_counter.sv
// Scoreboard bench: stimulus pushes expected state, a monitor pops and compares.
module tb_sync_updown_counter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // dut0: N10 wrap, dut1: N10 saturate, dut2/dut3: N16 cascaded pair
    logic [2:0]      en_i;
    logic [2:0]      up_i;
    logic [2:0]      ld_i;
    logic [2:0][3:0] lv_i;
    logic [3:0][3:0] q_o;
    logic [3:0]      w_o;
    logic [3:0]      ab_o;
    logic [3:0]      tc_o;

    sync_updown_counter #(.WIDTH(4), .MOD_N(10), .SATURATE(0)) dut0 (
        .clk(clk), .rst(rst), .en(en_i[0]), .up(up_i[0]), .load(ld_i[0]),
        .load_val(lv_i[0]), .q(q_o[0]), .tc(tc_o[0]), .wrap(w_o[0]), .at_bound(ab_o[0]));

    sync_updown_counter #(.WIDTH(4), .MOD_N(10), .SATURATE(1)) dut1 (
        .clk(clk), .rst(rst), .en(en_i[1]), .up(up_i[1]), .load(ld_i[1]),
        .load_val(lv_i[1]), .q(q_o[1]), .tc(tc_o[1]), .wrap(w_o[1]), .at_bound(ab_o[1]));

    sync_updown_counter #(.WIDTH(4), .MOD_N(16), .SATURATE(0)) dut2 (
        .clk(clk), .rst(rst), .en(en_i[2]), .up(up_i[2]), .load(ld_i[2]),
        .load_val(lv_i[2]), .q(q_o[2]), .tc(tc_o[2]), .wrap(w_o[2]), .at_bound(ab_o[2]));

    sync_updown_counter #(.WIDTH(4), .MOD_N(16), .SATURATE(0)) dut3 (
        .clk(clk), .rst(rst), .en(tc_o[2]), .up(1'b1), .load(1'b0),
        .load_val(4'd0), .q(q_o[3]), .tc(tc_o[3]), .wrap(w_o[3]), .at_bound(ab_o[3]));

    typedef struct {
        int       dut;
        int       id;
        logic [3:0] q;
        logic     w;
        logic     a;
        logic     t;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   vec_id  = 0;

    task automatic cmp(input int id, input int d, input string what, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL v%0d dut%0d %s: got %0d want %0d", id, d, what, got, want);
        end
    endtask

    // Monitor: compares at posedge+3 (or 3 time units after async reset)
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or posedge rst);
            #3;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                cmp(e.id, e.dut, "q",        int'(q_o[e.dut]),  int'(e.q));
                cmp(e.id, e.dut, "wrap",     int'(w_o[e.dut]),  int'(e.w));
                cmp(e.id, e.dut, "at_bound", int'(ab_o[e.dut]), int'(e.a));
                cmp(e.id, e.dut, "tc",       int'(tc_o[e.dut]), int'(e.t));
            end
        end
    end

    task automatic expect_now(input int d, input logic [3:0] eq, input logic ew,
                              input logic ea, input logic et);
        sb.push_back('{dut: d, id: vec_id, q: eq, w: ew, a: ea, t: et});
        vec_id++;
    endtask

    // One clock on dut d (others idle); expectation is state after the edge,
    // with tc evaluated while the same inputs are still applied.
    task automatic cyc(input int d, input logic e, input logic u, input logic l,
                       input logic [3:0] v, input logic [3:0] eq, input logic ew,
                       input logic ea, input logic et);
        @(negedge clk); #1;
        en_i = '0;
        ld_i = '0;
        en_i[d] = e;
        up_i[d] = u;
        ld_i[d] = l;
        lv_i[d] = v;
        @(posedge clk); #1;
        expect_now(d, eq, ew, ea, et);
    endtask

    initial begin
        rst  = 1'b1;
        en_i = '0;
        up_i = '1;
        ld_i = '0;
        lv_i = '0;

        // Reset state of all instances
        @(negedge clk); #1;
        for (int d = 0; d < 4; d++) expect_now(d, 4'd0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk); #1;
        rst = 1'b0;

        // Up count mod 10 with wrap pulse
        cyc(0, 1, 1, 0, 0, 4'd1, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 4'd2, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 4'd3, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 4'd4, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 4'd5, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 4'd6, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 4'd7, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 4'd8, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 4'd9, 0, 0, 1);
        cyc(0, 1, 1, 0, 0, 4'd0, 1, 0, 0);
        cyc(0, 1, 1, 0, 0, 4'd1, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 4'd2, 0, 0, 0);

        // Down count from 0: load with en=1 (load wins), then wrap to 9
        cyc(0, 1, 0, 1, 0, 4'd0, 0, 0, 1);
        cyc(0, 1, 0, 0, 0, 4'd9, 1, 0, 0);
        cyc(0, 1, 0, 0, 0, 4'd8, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 4'd7, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 4'd7, 0, 0, 0);

        // Load clamp and load beating the terminal condition
        cyc(0, 0, 1, 1, 15, 4'd9, 0, 0, 0);
        cyc(0, 0, 1, 1, 10, 4'd9, 0, 0, 0);
        cyc(0, 1, 1, 1, 3,  4'd3, 0, 0, 0);
        cyc(0, 0, 1, 1, 9,  4'd9, 0, 0, 0);
        cyc(0, 1, 1, 1, 5,  4'd5, 0, 0, 0);

        // Saturating instance
        cyc(1, 1, 1, 1, 8, 4'd8, 0, 0, 0);
        cyc(1, 1, 1, 0, 0, 4'd9, 0, 0, 1);
        cyc(1, 1, 1, 0, 0, 4'd9, 0, 1, 1);
        cyc(1, 1, 1, 0, 0, 4'd9, 0, 1, 1);
        cyc(1, 0, 1, 0, 0, 4'd9, 0, 1, 0);
        cyc(1, 0, 0, 0, 0, 4'd9, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 4'd8, 0, 0, 0);
        cyc(1, 0, 0, 1, 0, 4'd0, 0, 1, 0);
        cyc(1, 1, 0, 0, 0, 4'd0, 0, 1, 1);
        cyc(1, 1, 1, 0, 0, 4'd1, 0, 0, 0);

        // Asynchronous reset mid-count
        cyc(0, 0, 1, 1, 6, 4'd6, 0, 0, 0);
        @(negedge clk); #1;
        en_i = '0;
        ld_i = '0;
        en_i[0] = 1'b1;
        up_i[0] = 1'b1;
        rst = 1'b1;
        for (int d = 0; d < 4; d++) expect_now(d, 4'd0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk); #1;
        en_i = '0;
        rst = 1'b0;
        cyc(0, 1, 1, 0, 0, 4'd1, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 4'd2, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 4'd3, 0, 0, 0);

        // Cascade: dut3 advances once per 16 clocks of dut2
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk); #1;
            en_i = '0;
            ld_i = '0;
            en_i[2] = 1'b1;
            up_i[2] = 1'b1;
            @(posedge clk); #1;
            expect_now(2, 4'(k % 16), (k % 16) == 0, 1'b0, (k % 16) == 15);
            expect_now(3, 4'(k / 16), 1'b0, 1'b0, 1'b0);
        end

        @(negedge clk); #1;
        en_i = '0;
        repeat (2) @(posedge clk);
        #5;
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
